mult_issue_queue: RTL and testbench

Request buffer and sequencer sitting directly upstream of the shift-add multiplier. Accepts tagged operand pairs over a valid/ready interface into a small FIFO, issues them one at a time to the multiplier with a one-cycle start pulse, waits for done, and returns the 2*WIDTH-bit product with its tag over a valid/ready response interface. Exactly one operation is outstanding at the multiplier at any time, and responses leave in request order.

---
 rtl/mult_issue_queue_pkg.sv | 29 ++
 rtl/mult_issue_queue_if.sv | 49 ++++
 rtl/mult_issue_queue_fifo.sv | 69 ++++++
 rtl/mult_issue_queue.sv | 124 ++++++++++++
 tb/tb_mult_issue_queue.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_issue_queue_pkg.sv
// ============================================================================
// Module   : mult_issue_queue_pkg
// Brief    : Shared widths, FSM state encoding and request record for the
//            multiplier issue queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_issue_queue_pkg;

    localparam int width_p = 32;
    localparam int TAG_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } issue_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [width_p-1:0] multiplicand;
        logic [width_p-1:0] multiplier;
    } issue_req_t;

endpackage

`default_nettype wire

// File: rtl/mult_issue_queue_if.sv
// ============================================================================
// Module   : mult_issue_queue_if
// Brief    : Request, multiplier and response signal bundle for the issue
//            queue; slave is the queue, master is its environment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_issue_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [WIDTH-1:0]     req_multiplicand_i;
    logic [WIDTH-1:0]     req_multiplier_i;
    logic [TAG_W-1:0]     req_tag_i;
    logic                 mul_start_o;
    logic [WIDTH-1:0]     mul_multiplicand_o;
    logic [WIDTH-1:0]     mul_multiplier_o;
    logic                 mul_ready_i;
    logic                 mul_done_i;
    logic [2*WIDTH-1:0]   mul_product_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [2*WIDTH-1:0]   rsp_product_o;
    logic [TAG_W-1:0]     rsp_tag_o;
    logic [c_CNT_W-1:0]   count_o;

    modport slave (
        input  req_valid_i, req_multiplicand_i, req_multiplier_i, req_tag_i,
        input  mul_ready_i, mul_done_i, mul_product_i, rsp_ready_i,
        output req_ready_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o,
        output rsp_valid_o, rsp_product_o, rsp_tag_o, count_o
    );

    modport master (
        output req_valid_i, req_multiplicand_i, req_multiplier_i, req_tag_i,
        output mul_ready_i, mul_done_i, mul_product_i, rsp_ready_i,
        input  req_ready_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o,
        input  rsp_valid_o, rsp_product_o, rsp_tag_o, count_o
    );

endinterface

`default_nettype wire

// File: rtl/mult_issue_queue_fifo.sv
// ============================================================================
// Module   : mult_issue_fifo
// Brief    : Generic DEPTH-entry synchronous FIFO exposing the head entry,
//            occupancy, full and empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_issue_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     i_push,
    input  wire logic [DATA_W-1:0]        i_data,
    input  wire logic                     i_pop,
    output logic      [DATA_W-1:0]        o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_issue_queue.sv
// ============================================================================
// Module   : mult_issue_queue
// Brief    : Buffers tagged operand pairs and sequences them one at a time
//            through the shift-add multiplier, returning products in order.
//            Optional: MULT_ISSUE_ZERO_BYPASS_EN answers zero-operand requests
//            directly with product 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mult_issue_queue_if.slave bus
);
    import mult_issue_queue_pkg::*;

    issue_state_e           r_state;
    issue_state_e           w_next_state;
    issue_req_t             w_in_req;
    issue_req_t             w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_take_bypass;
    logic                   w_head_zero;
    logic [$clog2(DEPTH):0] w_count;
    logic [WIDTH-1:0]       r_mul_a;
    logic [WIDTH-1:0]       r_mul_b;
    logic [TAG_W-1:0]       r_tag;
    logic [2*WIDTH-1:0]     r_product;

    assign w_in_req = '{tag:          bus.req_tag_i,
                        multiplicand: bus.req_multiplicand_i,
                        multiplier:   bus.req_multiplier_i};

    mult_issue_fifo #(
        .DATA_W ($bits(issue_req_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (bus.req_valid_i),
        .i_data  (w_in_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    assign w_head_zero = (w_head.multiplicand == '0) || (w_head.multiplier == '0);
`else
    assign w_head_zero = 1'b0;
`endif

    assign bus.req_ready_o        = !w_full;
    assign bus.count_o            = w_count;
    assign bus.mul_start_o        = (r_state == ISSUE);
    assign bus.mul_multiplicand_o = r_mul_a;
    assign bus.mul_multiplier_o   = r_mul_b;
    assign bus.rsp_valid_o        = (r_state == HOLD);
    assign bus.rsp_product_o      = r_product;
    assign bus.rsp_tag_o          = r_tag;

    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_take_bypass = 1'b0;
        case (r_state)
            IDLE: begin
                // A zero-operand head skips the multiplier, so it does not wait for mul_ready_i.
                if (!w_empty && w_head_zero) begin
                    w_pop         = 1'b1;
                    w_take_bypass = 1'b1;
                    w_next_state  = HOLD;
                end else if (!w_empty && bus.mul_ready_i) begin
                    w_pop        = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (bus.mul_done_i)  w_next_state = HOLD;
            HOLD:    if (bus.rsp_ready_i) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_tag     <= '0;
            r_product <= '0;
        end else begin
            if (w_pop) begin
                r_mul_a <= w_head.multiplicand;
                r_mul_b <= w_head.multiplier;
                r_tag   <= w_head.tag;
            end
            if (w_take_bypass) begin
                r_product <= '0;
            end else if (r_state == WAIT && bus.mul_done_i) begin
                r_product <= bus.mul_product_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_issue_queue.sv
// ============================================================================
// Module   : tb_mult_issue_queue
// Brief    : Directed self-checking bench for mult_issue_queue with a simple
//            fixed-latency multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_issue_queue;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mult_issue_queue_if #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) bus ();

    mult_issue_queue #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 34;
    int n_start  = 0;
    int st_cyc   = 0;
    int push_cyc = 0;
    int rsp_cyc  = 0;
    logic [31:0] st_a = '0;
    logic [31:0] st_b = '0;
    logic [63:0] q_prod [$];
    logic [3:0]  q_tag  [$];

    // Multiplier model: done pulses lat cycles after the start pulse.
    logic        m_busy;
    logic        m_done;
    logic [63:0] m_prod;
    int          m_cnt;
    logic        stale_done = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (bus.mul_start_o) begin
                m_busy <= 1'b1;
                m_cnt  <= lat;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_done <= 1'b1;
                    m_prod <= 64'(bus.mul_multiplicand_o) * 64'(bus.mul_multiplier_o);
                    m_busy <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign bus.mul_ready_i   = !m_busy;
    assign bus.mul_done_i    = m_done | stale_done;
    assign bus.mul_product_i = stale_done ? 64'hDEAD_BEEF_DEAD_BEEF : m_prod;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mul_start_o) begin
            n_start <= n_start + 1;
            st_cyc  <= cyc;
            st_a    <= bus.mul_multiplicand_o;
            st_b    <= bus.mul_multiplier_o;
        end
        if (bus.req_valid_i && bus.req_ready_o) push_cyc <= cyc;
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            rsp_cyc <= cyc;
            q_prod.push_back(bus.rsp_product_o);
            q_tag.push_back(bus.rsp_tag_o);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int k = 0;
        bus.req_valid_i        = 1'b1;
        bus.req_multiplicand_i = a;
        bus.req_multiplier_i   = b;
        bus.req_tag_i          = t;
        while (!bus.req_ready_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("push_accept", 64'(bus.req_ready_o), 64'd1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int k = 0;
        while (q_tag.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(q_tag.size()), 64'(n));
    endtask

    logic [31:0] fa [5];
    logic [31:0] fb [5];
    logic [3:0]  ft [5];
    logic [63:0] fp [5];

    initial begin
        fa = '{32'hFFFF_FFFF, 32'd2, 32'd10, 32'h0001_0000, 32'hFFFF_FFFF};
        fb = '{32'hFFFF_FFFF, 32'd3, 32'd11, 32'h0001_0000, 32'd2};
        ft = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd9};
        fp = '{64'hFFFF_FFFE_0000_0001, 64'd6, 64'd110, 64'h1_0000_0000, 64'h1_FFFF_FFFE};

        bus.req_valid_i        = 1'b0;
        bus.req_multiplicand_i = '0;
        bus.req_multiplier_i   = '0;
        bus.req_tag_i          = '0;
        bus.rsp_ready_i        = 1'b1;

        // Reset state
        #12;
        check("rst_count",     64'(bus.count_o),            64'd0);
        check("rst_req_ready", 64'(bus.req_ready_o),        64'd1);
        check("rst_start",     64'(bus.mul_start_o),        64'd0);
        check("rst_mul_a",     64'(bus.mul_multiplicand_o), 64'd0);
        check("rst_mul_b",     64'(bus.mul_multiplier_o),   64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o),        64'd0);
        check("rst_rsp_prod",  bus.rsp_product_o,           64'd0);
        check("rst_rsp_tag",   64'(bus.rsp_tag_o),          64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single op with a 34-cycle multiplier
        lat = 34;
        push(32'd7, 32'd6, 4'd3);
        wait_rsp(1, 100, "single_wait");
        check("single_starts",   64'(n_start),            64'd1);
        check("single_a",        64'(st_a),               64'd7);
        check("single_b",        64'(st_b),               64'd6);
        check("single_issue_lat", 64'(st_cyc - push_cyc), 64'd2);
        check("single_rsp_lat",  64'(rsp_cyc - st_cyc),   64'd36);
        check("single_prod",     q_prod[0],               64'd42);
        check("single_tag",      64'(q_tag[0]),           64'd3);

        // Stale done in IDLE
        @(negedge clk);
        stale_done = 1'b1;
        @(negedge clk);
        stale_done = 1'b0;
        check("stale_valid",  64'(bus.rsp_valid_o), 64'd0);
        @(negedge clk);
        check("stale_valid2", 64'(bus.rsp_valid_o), 64'd0);
        check("stale_count",  64'(bus.count_o),     64'd0);
        check("stale_rsps",   64'(q_tag.size()),    64'd1);
        check("stale_starts", 64'(n_start),         64'd1);

        // Fill: five back-to-back requests
        lat = 8;
        for (int i = 0; i < 5; i++) push(fa[i], fb[i], ft[i]);
        check("fill_count", 64'(bus.count_o),     64'd4);
        check("fill_ready", 64'(bus.req_ready_o), 64'd0);
        wait_rsp(6, 150, "fill_wait");
        for (int i = 0; i < 5; i++) begin
            check("fill_prod", q_prod[i+1],       fp[i]);
            check("fill_tag",  64'(q_tag[i+1]),   64'(ft[i]));
        end
        check("fill_starts", 64'(n_start), 64'd6);

        // Response backpressure
        lat = 4;
        bus.rsp_ready_i = 1'b0;
        push(32'd5, 32'd5, 4'd6);
        push(32'd3, 32'd4, 4'd7);
        begin
            int k = 0;
            while (!bus.rsp_valid_o && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_prod",      bus.rsp_product_o,                 64'd25);
            check("bp_hold_valid_tag", 64'({bus.rsp_valid_o, bus.rsp_tag_o}), 64'h16);
        end
        check("bp_starts", 64'(n_start),     64'd7);
        check("bp_count",  64'(bus.count_o), 64'd1);
        bus.rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_restart_lat", 64'(st_cyc - rsp_cyc), 64'd2);
        wait_rsp(8, 60, "bp_wait");
        check("bp_prod_a", q_prod[6],     64'd25);
        check("bp_tag_a",  64'(q_tag[6]), 64'd6);
        check("bp_prod_b", q_prod[7],     64'd12);
        check("bp_tag_b",  64'(q_tag[7]), 64'd7);

        // Reset mid-WAIT with three entries queued
        lat = 30;
        for (int i = 0; i < 4; i++) push(32'(i + 1), 32'(i + 1), 4'(10 + i));
        repeat (3) @(negedge clk);
        check("rw_count_pre", 64'(bus.count_o), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rw_count",     64'(bus.count_o),     64'd0);
        check("rw_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rw_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("rw_start",     64'(bus.mul_start_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rw_no_rsp",    64'(q_tag.size()),    64'd8);
        check("rw_starts",    64'(n_start),         64'd9);
        check("rw_count_end", 64'(bus.count_o),     64'd0);

        // Zero operand
        lat = 4;
        push(32'd0, 32'd9, 4'd5);
        wait_rsp(9, 60, "zero_wait");
        check("zero_prod", q_prod[8],     64'd0);
        check("zero_tag",  64'(q_tag[8]), 64'd5);
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
        check("zero_starts", 64'(n_start),             64'd9);
        check("zero_lat",    64'(rsp_cyc - push_cyc),  64'd2);
`else
        check("zero_starts", 64'(n_start),             64'd10);
        check("zero_lat",    64'(rsp_cyc - push_cyc),  64'd8);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
